// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared state encoding, register offsets and CTRL bit positions for the ROM loader.
package rom_load_pkg;
    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        LOAD    = 3'd1,
        FLUSH   = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4
    } state_t;
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_BASE = 2'd1;
    localparam logic [1:0] REG_DATA = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;
    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO; overflowing pushes and empty pops are dropped.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_din,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic w_push, w_pop;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rp];
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= w_push ? r_wp + AW'(1) : r_wp;
            r_rp  <= w_pop ? r_rp + AW'(1) : r_rp;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: Avalon-MM ROM loader; buffers bytes, writes them to the cartridge ROM and
// sequences the NES reset, then hands the ROM port to the NES read path in RUN.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int REL_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        AVL_ADDR,
    input  logic              AVL_CS,
    input  logic              AVL_WRITE,
    input  logic              AVL_READ,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic              AVL_WAITREQUEST,
    input  logic [ADDR_W-1:0] NES_ADDR,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic [7:0]        TO_ROM,
    output logic              WRITE_ROM,
    output logic              NES_RESET,
    output logic              LOADING
);
    localparam int CW = $clog2(REL_CYCLES) + 1;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    state_t            r_state;
    logic [CW-1:0]     r_rel_cnt;
    logic              r_nes_reset, r_loading, r_write_rom;
    logic [7:0]        r_to_rom;
    logic [ADDR_W-1:0] r_wr_addr, r_ptr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_readdata, w_rdata;
    logic w_wr, w_rd, w_push, w_pop, w_base, w_start, w_done, w_enter_load;
    logic w_full, w_empty, w_unused;
    logic [7:0] w_dout;
    assign w_wr         = AVL_CS & AVL_WRITE;
    assign w_rd         = AVL_CS & AVL_READ;
    assign w_push       = w_wr & (AVL_ADDR == REG_DATA) & ~w_full;
    assign w_base       = w_wr & (AVL_ADDR == REG_BASE);
    assign w_start      = w_wr & (AVL_ADDR == REG_CTRL) & AVL_WRITEDATA[CTRL_START];
    assign w_done       = w_wr & (AVL_ADDR == REG_CTRL) & AVL_WRITEDATA[CTRL_DONE];
    assign w_pop        = ((r_state == LOAD) | (r_state == FLUSH)) & ~w_empty;
    assign w_enter_load = w_start & ((r_state == HOLD) | (r_state == RUN));
    assign w_unused     = &{1'b0, AVL_WRITEDATA[31:ADDR_W]};
    assign AVL_WAITREQUEST = w_wr & (AVL_ADDR == REG_DATA) & w_full;
    assign AVL_READDATA = r_readdata;
    assign ROM_ADDR     = (r_state == RUN) ? NES_ADDR : r_wr_addr;
    assign WRITE_ROM    = r_write_rom & (r_state != RUN);
    assign TO_ROM       = r_to_rom;
    assign NES_RESET    = r_nes_reset;
    assign LOADING      = r_loading;
    assign w_rdata = (AVL_ADDR == REG_CTRL) ? {29'b0, w_empty, w_full, r_loading} :
                     (AVL_ADDR == REG_BASE) ? 32'(r_ptr) :
                     (AVL_ADDR == REG_DATA) ? {29'b0, r_state} :
                     (AVL_ADDR == REG_STAT) ? 32'(r_count) : '0;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_din  (AVL_WRITEDATA[7:0]),
        .o_dout (w_dout),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    // A BASE write overrides the post-pop increment; the popped byte already latched the old pointer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_write_rom <= 1'b0;
            r_to_rom    <= '0;
            r_wr_addr   <= '0;
            r_ptr       <= '0;
            r_count     <= '0;
            r_readdata  <= '0;
        end else begin
            r_write_rom <= w_pop;
            r_to_rom    <= w_pop ? w_dout : r_to_rom;
            r_wr_addr   <= w_pop ? r_ptr : r_wr_addr;
            r_ptr       <= w_base ? AVL_WRITEDATA[ADDR_W-1:0] : w_pop ? r_ptr + ADDR_W'(1) : r_ptr;
            r_count     <= w_enter_load ? '0 : (w_pop && r_count != CNT_MAX) ? r_count + (ADDR_W+1)'(1) : r_count;
            r_readdata  <= w_rd ? w_rdata : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= HOLD;
            r_rel_cnt   <= '0;
            r_nes_reset <= 1'b1;
            r_loading   <= 1'b1;
        end else begin
            case (r_state)
                HOLD, RUN: if (w_start) begin
                    r_state     <= LOAD;
                    r_nes_reset <= 1'b1;
                    r_loading   <= 1'b1;
                end
                LOAD: if (w_done) r_state <= FLUSH;
                FLUSH: if (w_empty && !w_push) begin
                    r_state   <= RELEASE;
                    r_rel_cnt <= CW'(REL_CYCLES - 1);
                end
                RELEASE: if (r_rel_cnt == '0) begin
                    r_state     <= RUN;
                    r_nes_reset <= 1'b0;
                    r_loading   <= 1'b0;
                end else begin
                    r_rel_cnt <= r_rel_cnt - CW'(1);
                end
                default: r_state <= HOLD;
            endcase
        end
    end
endmodule
